// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter family (serial and barrel shifters plus benches):
// FSM state encoding, direction / shift-type constants and a fill-bit helper.
package shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT   = 1'b0;
  localparam logic DIR_LEFT    = 1'b1;
  localparam logic SHIFT_LOGIC = 1'b0;
  localparam logic SHIFT_ARITH = 1'b1;

  // Bit inserted by a plain (non-rotating) shift: the sign bit only for an
  // arithmetic right shift, zero in every other case.
  function automatic logic arith_fill(input logic dir, input logic arith, input logic msb);
    return (dir == DIR_RIGHT && arith == SHIFT_ARITH) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/shift_step_1bit.sv
// One-bit shift step: moves data one position left (dir=1) or right (dir=0)
// and inserts the supplied fill bit into the vacated position. Purely combinational.
module shift_step_1bit
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  // Each output bit takes its neighbour towards the shift source, or the fill bit at the edge.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign shifted[gi] = (dir == DIR_LEFT) ? fill : data[gi+1];
    end else if (gi == WIDTH - 1) begin : g_msb
      assign shifted[gi] = (dir == DIR_LEFT) ? data[gi-1] : fill;
    end else begin : g_mid
      assign shifted[gi] = (dir == DIR_LEFT) ? data[gi-1] : data[gi+1];
    end
  end

endmodule

// File: rtl/serial_shifter.sv
// Bit-serial shifter: takes one operand over valid/ready, shifts it one bit per
// clock (left/right, logical/arithmetic) and returns the result over valid/ready.
// Optional feature macro: SERIAL_SHIFTER_ROTATE_EN adds in_rotate, which turns the
// shift into a rotate (fill = bit shifted out) and overrides in_arith.
module serial_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  input  logic             in_dir,
  input  logic             in_arith,
`ifdef SERIAL_SHIFTER_ROTATE_EN
  input  logic             in_rotate,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [SHW-1:0]   count_reg, count_next;
  logic             dir_reg, arith_reg;
  logic             load;
  logic             fill_bit;
  logic [WIDTH-1:0] step_data;
`ifdef SERIAL_SHIFTER_ROTATE_EN
  logic             rotate_reg;
`endif

  // Fill bit for the current step, taken from the latched operation mode.
  always_comb begin
`ifdef SERIAL_SHIFTER_ROTATE_EN
    if (rotate_reg) begin
      fill_bit = (dir_reg == DIR_LEFT) ? data_reg[WIDTH-1] : data_reg[0];
    end else begin
      fill_bit = arith_fill(dir_reg, arith_reg, data_reg[WIDTH-1]);
    end
`else
    fill_bit = arith_fill(dir_reg, arith_reg, data_reg[WIDTH-1]);
`endif
  end

  shift_step_1bit #(.WIDTH(WIDTH)) u_step (
    .data    (data_reg),
    .dir     (dir_reg),
    .fill    (fill_bit),
    .shifted (step_data)
  );

  // Next-state, datapath and counter control; zero-amount operands skip SHIFT.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    count_next = count_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          data_next  = in_data;
          count_next = in_amount;
          state_next = (in_amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_next  = step_data;
        count_next = count_reg - SHW'(1);
        if (count_reg == SHW'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, data and counter registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      count_reg <= count_next;
    end
  end

  // Operation mode is captured only on the accept edge so in_* may change afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_reg    <= DIR_RIGHT;
      arith_reg  <= SHIFT_LOGIC;
`ifdef SERIAL_SHIFTER_ROTATE_EN
      rotate_reg <= 1'b0;
`endif
    end else if (load) begin
      dir_reg    <= in_dir;
      arith_reg  <= in_arith;
`ifdef SERIAL_SHIFTER_ROTATE_EN
      rotate_reg <= in_rotate;
`endif
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_DONE);
  assign out_data  = data_reg;

endmodule

// File: tb/tb_serial_shifter.sv
// Scoreboard bench for serial_shifter (WIDTH=8). The driver pushes the expected
// result and latency at each accept; a monitor pops and compares whenever out_valid rises.
// Define SERIAL_SHIFTER_ROTATE_EN to also exercise the rotate feature.
module tb_serial_shifter;
  import shifter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_amount = '0;
  logic       in_dir = 1'b0;
  logic       in_arith = 1'b0;
`ifdef SERIAL_SHIFTER_ROTATE_EN
  logic       in_rotate = 1'b0;
`endif
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;

  serial_shifter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_dir    (in_dir),
    .in_arith  (in_arith),
`ifdef SERIAL_SHIFTER_ROTATE_EN
    .in_rotate (in_rotate),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [7:0] data;
    int         acc;  // cycle count right after the accept edge
    int         lat;  // edges from accept edge until out_valid is seen
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: one pop and compare per rising out_valid, sampled on the falling edge.
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !out_valid) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'(out_data), 32'hDEAD);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_data"}, 32'(out_data), 32'(e.data));
          check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
          $display("result %-10s data=%02h (req %02h) latency=%0d (req %0d)",
                   e.name, out_data, e.data, cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Offer one operand; when expect_it is set the expected result is queued at the accept edge.
  // Expected latency: k edges for amount k >= 1; a zero amount goes straight to DONE on the
  // accept edge, so out_valid is visible in the very next cycle.
  task automatic send(input string name, input logic [7:0] d, input logic [2:0] amt,
                      input logic dir, input logic arith, input logic rot,
                      input logic [7:0] req);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    in_data   = d;
    in_amount = amt;
    in_dir    = dir;
    in_arith  = arith;
`ifdef SERIAL_SHIFTER_ROTATE_EN
    in_rotate = rot;
`else
    if (rot) $display("note: rotate requested without rotate support");
`endif
    in_valid  = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.name = name;
    e.data = req;
    e.acc  = cyc + 1;
    e.lat  = int'(amt);
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while ((sb_q.size() != 0 || out_valid || !in_ready) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0 || !in_ready) begin
      check({name, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    rst_n = 1'b1;

    // Main function.
    send("l3_logic", 8'b1001_0110, 3'd3, DIR_LEFT,  SHIFT_LOGIC, 1'b0, 8'b1011_0000); wait_drain("l3_logic");
    send("r3_arith", 8'b1001_0110, 3'd3, DIR_RIGHT, SHIFT_ARITH, 1'b0, 8'b1111_0010); wait_drain("r3_arith");
    send("r3_logic", 8'b1001_0110, 3'd3, DIR_RIGHT, SHIFT_LOGIC, 1'b0, 8'b0001_0010); wait_drain("r3_logic");
    send("amt0",     8'hA5,        3'd0, DIR_LEFT,  SHIFT_LOGIC, 1'b0, 8'hA5);        wait_drain("amt0");
    send("r7_arith", 8'h80,        3'd7, DIR_RIGHT, SHIFT_ARITH, 1'b0, 8'hFF);        wait_drain("r7_arith");
    send("l1_arith", 8'h96,        3'd1, DIR_LEFT,  SHIFT_ARITH, 1'b0, 8'h2C);        wait_drain("l1_arith");
    send("r7_logic", 8'h96,        3'd7, DIR_RIGHT, SHIFT_LOGIC, 1'b0, 8'h01);        wait_drain("r7_logic");
    send("r4_apos",  8'h7F,        3'd4, DIR_RIGHT, SHIFT_ARITH, 1'b0, 8'h07);        wait_drain("r4_apos");

    // Back-pressure: hold out_ready low in DONE while another operand is offered.
    out_ready = 1'b0;
    send("hold", 8'h0F, 3'd2, DIR_LEFT, SHIFT_LOGIC, 1'b0, 8'h3C);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("hold_reach_done", 32'(out_valid), 32'd1);
    in_data   = 8'hF0;
    in_amount = 3'd1;
    in_dir    = DIR_RIGHT;
    in_arith  = SHIFT_ARITH;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data",      32'(out_data),  32'h3C);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_busy",      32'(busy),      32'd1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_data",      32'(out_data),  32'h3C);
    out_ready = 1'b1;
    send("after_hold", 8'hF0, 3'd1, DIR_RIGHT, SHIFT_ARITH, 1'b0, 8'hF8); wait_drain("after_hold");

    // Reset in the middle of a 5-bit shift, after two shift edges.
    @(negedge clk);
    in_data   = 8'hC3;
    in_amount = 3'd5;
    in_dir    = DIR_LEFT;
    in_arith  = SHIFT_LOGIC;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_out_data",  32'(out_data),  32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send("post_reset", 8'h81, 3'd1, DIR_RIGHT, SHIFT_LOGIC, 1'b0, 8'h40); wait_drain("post_reset");

`ifdef SERIAL_SHIFTER_ROTATE_EN
    send("rotl3",     8'b1001_0110, 3'd3, DIR_LEFT,  SHIFT_LOGIC, 1'b1, 8'b1011_0100); wait_drain("rotl3");
    send("rotr1",     8'b1001_0110, 3'd1, DIR_RIGHT, SHIFT_LOGIC, 1'b1, 8'b0100_1011); wait_drain("rotr1");
    send("rotr_arith", 8'h01,       3'd1, DIR_RIGHT, SHIFT_ARITH, 1'b1, 8'h80);        wait_drain("rotr_arith");
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
